// File: rtl/link_carrier_tx.sv
// ----------------------------------------------------------------------------
// link_carrier_tx
//
// Transmit-side carrier generator for the SWIPT link. Produces the square-wave
// `link` carrier that the receiver PLL/PFD locks onto, at a commanded frequency
// in Hz. The frequency is synthesised with a phase accumulator that adds
// 2*f_cur every clk and wraps at CLK_HZ, toggling `link` on each wrap, so the
// long-run period is exactly CLK_HZ/f_cur clks. Frequency changes are
// slew-limited to STEP Hz per carrier period and applied only on rising edges
// of `link`, so the receiver never sees a runt pulse.
//
// Ports
//   clk          in   1   system clock
//   nrst         in   1   synchronous reset, active high
//   en           in   1   carrier enable
//   f_req        in   32  requested frequency, unsigned Hz
//   f_valid      in   1   f_req valid
//   f_ready      out  1   request can be accepted
//   link         out  1   carrier output (registered)
//   f_cur        out  32  frequency currently generated, Hz
//   alive        out  1   carrier running (state RUN)
//   ramping      out  1   running and f_cur has not reached the target
//   o_dbg_state  out  2   FSM state for observation (0 IDLE, 1 RUN, 2 STOP)
//
// Handshake: a request is accepted on a rising clk edge where f_valid and
// f_ready are both high; f_req is sampled on that edge. f_valid may be held
// high without acceptance while f_ready is low (reset or STOP), and the
// request stays pending until the edge where f_ready is high.
// ----------------------------------------------------------------------------
module link_carrier_tx #(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned F_MIN     = 30000,
    parameter int unsigned F_MAX     = 50000,
    parameter int unsigned F_DEFAULT = 40000,
    parameter int unsigned STEP      = 1000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic [31:0] f_req,
    input  logic        f_valid,
    output logic        f_ready,
    output logic        link,
    output logic [31:0] f_cur,
    output logic        alive,
    output logic        ramping,
    output logic [1:0]  o_dbg_state
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [32:0] CLK_HZ_W    = 33'(CLK_HZ);
    localparam logic [31:0] F_MIN_W     = 32'(F_MIN);
    localparam logic [31:0] F_MAX_W     = 32'(F_MAX);
    localparam logic [31:0] F_DEFAULT_W = 32'(F_DEFAULT);
    localparam logic [31:0] STEP_W      = 32'(STEP);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic        r_link;
    logic [32:0] r_acc;
    logic [31:0] r_f_cur;
    logic [31:0] r_f_tgt;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_accept;
    logic [31:0] w_f_clamped;
    logic [32:0] w_sum;
    logic        w_wrap;
    logic [32:0] w_acc_next;
    logic        w_rise;
    logic        w_up;
    logic [31:0] w_dist;
    logic [31:0] w_delta;
    logic [31:0] w_f_stepped;

    assign f_ready  = !nrst && (r_state != ST_STOP);
    assign w_accept = f_valid && f_ready;

    // Full 32-bit compare, so huge requests saturate at F_MAX rather than
    // aliasing into the legal band.
    always_comb begin
        w_f_clamped = f_req;
        if (f_req < F_MIN_W) begin
            w_f_clamped = F_MIN_W;
        end else if (f_req > F_MAX_W) begin
            w_f_clamped = F_MAX_W;
        end
    end

    // Phase accumulator. Adding 2*f_cur per clk and wrapping at CLK_HZ gives
    // one toggle per half period; the remainder carried across wraps makes
    // the half periods alternate between floor and ceil of CLK_HZ/(2*f_cur).
    // f_cur <= F_MAX and 2*F_MAX < CLK_HZ, so the 33-bit sum cannot overflow.
    assign w_sum      = r_acc + {r_f_cur, 1'b0};
    assign w_wrap     = (w_sum >= CLK_HZ_W);
    assign w_acc_next = w_wrap ? (w_sum - CLK_HZ_W) : w_sum;

    // A wrap while link is low is a 0->1 toggle, i.e. a period boundary.
    assign w_rise = w_wrap && !r_link;

    // Slew limiter: move f_cur toward the target by at most STEP. When the
    // two are equal the distance is zero and f_cur is left unchanged.
    assign w_up        = (r_f_tgt > r_f_cur);
    assign w_dist      = w_up ? (r_f_tgt - r_f_cur) : (r_f_cur - r_f_tgt);
    assign w_delta     = (w_dist > STEP_W) ? STEP_W : w_dist;
    assign w_f_stepped = w_up ? (r_f_cur + w_delta) : (r_f_cur - w_delta);

    // ------------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_state <= ST_IDLE;
            r_link  <= 1'b0;
            r_acc   <= '0;
            r_f_cur <= F_DEFAULT_W;
            r_f_tgt <= F_DEFAULT_W;
        end else begin
            // Target update. Any step taken on this same edge reads the old
            // r_f_tgt, so a request never shortens the current period.
            if (w_accept) begin
                r_f_tgt <= w_f_clamped;
            end

            case (r_state)
                ST_IDLE: begin
                    // Carrier stopped: no ramp, the request takes effect at once.
                    if (w_accept) begin
                        r_f_cur <= w_f_clamped;
                    end
                    // Entry edge starts a fresh high half period from zero phase.
                    if (en) begin
                        r_state <= ST_RUN;
                        r_link  <= 1'b1;
                        r_acc   <= '0;
                    end
                end

                ST_RUN: begin
                    if (!en && !r_link) begin
                        // Disabled during the low half: stop here, link is already
                        // low, and the pending rising edge is suppressed.
                        r_state <= ST_IDLE;
                        r_acc   <= '0;
                    end else begin
                        if (w_wrap) begin
                            r_link <= !r_link;
                        end
                        if (w_rise) begin
                            r_f_cur <= w_f_stepped;
                        end

                        if (!en && w_wrap) begin
                            // Disabled on the very edge the high half ends: the
                            // falling toggle completes the period, go straight idle.
                            r_state <= ST_IDLE;
                            r_acc   <= '0;
                        end else begin
                            r_acc <= w_acc_next;
                            if (!en) begin
                                // Disabled during the high half: finish it in STOP.
                                r_state <= ST_STOP;
                            end
                        end
                    end
                end

                ST_STOP: begin
                    // link is high here; the next wrap is its falling edge.
                    if (w_wrap) begin
                        r_state <= ST_IDLE;
                        r_link  <= 1'b0;
                        r_acc   <= '0;
                    end else begin
                        r_acc <= w_acc_next;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_link  <= 1'b0;
                    r_acc   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (registers or decodes of registers only)
    // ------------------------------------------------------------------------
    assign link        = r_link;
    assign f_cur       = r_f_cur;
    assign alive       = (r_state == ST_RUN);
    assign ramping     = alive && (r_f_cur != r_f_tgt);
    assign o_dbg_state = r_state;

endmodule
